imem_stream_loader: RTL and testbench

- Writer side of the instruction-fetch path: receives a byte stream carrying a program image and writes it as 32-bit words into instruction memory.
- Holds the processor core in reset until the image is fully loaded, then releases it.
- Sits between the bench/host byte source and the single-cycle core's instruction memory write port.

---
 rtl/imem_stream_loader_if.sv | 22 ++
 rtl/imem_stream_loader.sv | 126 ++++++++++++
 tb/tb_imem_stream_loader.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_stream_loader_if.sv
// Byte-stream input plus instruction-memory write port of the program loader.
// The master modport belongs to the host/memory side and the slave modport to the loader.
interface imem_stream_loader_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  s_valid;
  logic [7:0]            s_data;
  logic                  s_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;

  modport master (
    output s_valid, s_data,
    input  s_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_stream_loader.sv
// Loads a length-prefixed little-endian byte stream into instruction memory, then releases core reset.
// Each word is 4 byte cycles plus 1 write cycle; s_ready drops during WRITE/DONE/ERR so the source stalls.
module imem_stream_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  imem_stream_loader_if.slave   bus,
  input  logic                  reload,
  output logic                  core_reset,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  typedef enum logic [2:0] {
    HDR0,
    HDR1,
    DATA,
    WRITE,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [16:0] CAPACITY = 17'(1) << ADDR_WIDTH;

  state_t                state_q, state_d;
  logic [15:0]           count_q, count_d;
  logic [1:0]            idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [ADDR_WIDTH:0]   wl_q, wl_d;
  logic [15:0]           hdr_n;
  logic                  rdy;
  logic                  xfer;

  assign rdy  = (state_q == HDR0) || (state_q == HDR1) || (state_q == DATA);
  assign xfer = bus.s_valid && rdy;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= HDR0;
      count_q <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wl_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wl_q    <= wl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wl_d    = wl_q;
    hdr_n   = {bus.s_data, count_q[7:0]};

    case (state_q)
      HDR0: begin
        if (xfer) begin
          count_d[7:0] = bus.s_data;
          state_d      = HDR1;
        end
      end
      HDR1: begin
        if (xfer) begin
          count_d = hdr_n;
          if (hdr_n == 16'd0) begin
            state_d = ST_DONE;
          end else if ({1'b0, hdr_n} > CAPACITY) begin
            state_d = ST_ERR;
          end else begin
            state_d = DATA;
            idx_d   = '0;
            addr_d  = '0;
          end
        end
      end
      DATA: begin
        if (xfer) begin
          wdata_d[8*idx_q +: 8] = bus.s_data;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = WRITE;
        end
      end
      WRITE: begin
        wl_d = wl_q + (ADDR_WIDTH+1)'(1);
        // Compare at 17 bits so a full-capacity image ends without the address wrapping.
        if (17'(wl_d) == {1'b0, count_q}) begin
          state_d = ST_DONE;
        end else begin
          addr_d  = addr_q + ADDR_WIDTH'(1);
          state_d = DATA;
        end
      end
      ST_DONE, ST_ERR: begin
        if (reload) begin
          state_d = HDR0;
          wl_d    = '0;
          addr_d  = '0;
        end
      end
      default: state_d = HDR0;
    endcase
  end

  // Outputs are forced to their reset values for as long as reset is held.
  assign bus.s_ready    = rdy && !reset;
  assign bus.imem_we    = (state_q == WRITE) && !reset;
  assign bus.imem_addr  = reset ? '0 : addr_q;
  assign bus.imem_wdata = reset ? '0 : wdata_q;
  assign done           = (state_q == ST_DONE) && !reset;
  assign error          = (state_q == ST_ERR) && !reset;
  assign core_reset     = reset || (state_q != ST_DONE);
  assign words_loaded   = reset ? '0 : wl_q;

endmodule

// File: tb/tb_imem_stream_loader.sv
// Directed bench for imem_stream_loader: inputs change 1 time unit after posedge, outputs sampled on negedge.
module tb_imem_stream_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       reload = 1'b0;
  logic       core_reset, done, error;
  logic [8:0] words_loaded;

  imem_stream_loader_if #(.ADDR_WIDTH(8)) bus ();

  imem_stream_loader #(.ADDR_WIDTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .reload       (reload),
    .core_reset   (core_reset),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int done_cyc = -1;
  int xfer_cyc[$];
  int wr_cyc[$];
  logic [7:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  logic [7:0]  tx[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.s_valid && bus.s_ready) xfer_cyc.push_back(cyc);
    if (bus.imem_we) begin
      wr_addr.push_back(bus.imem_addr);
      wr_data.push_back(bus.imem_wdata);
      wr_cyc.push_back(cyc);
    end
    if (done && done_cyc < 0) done_cyc = cyc;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    xfer_cyc.delete();
    wr_cyc.delete();
    wr_addr.delete();
    wr_data.delete();
    done_cyc = -1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic rdy;
    int   n;
    bus.s_valid = 1'b1;
    bus.s_data  = b;
    n = 0;
    do begin
      @(negedge clk);
      rdy = bus.s_ready;
      tick();
      n++;
    end while (!rdy && n < 50);
    if (!rdy) chk("byte_accept_timeout", 64'(rdy), 64'd1);
  endtask

  // Sends tx[first..last] with 'gap' idle cycles between bytes.
  task automatic send_range(input int first, input int last, input int gap);
    for (int i = first; i <= last; i++) begin
      if (gap > 0 && i > first) begin
        bus.s_valid = 1'b0;
        repeat (gap) tick();
      end
      send_byte(tx[i]);
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_end(input int bound);
    int k;
    for (k = 0; k < bound; k++) begin
      @(negedge clk);
      if (done || error) break;
    end
    if (!(done || error)) chk("end_timeout", 64'(done || error), 64'd1);
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.s_valid = 1'b0;
    reload = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    clear_log();
  endtask

  task automatic load_two_word_tx();
    tx = {8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00};
  endtask

  task automatic chk_two_word(input string p);
    chk({p, "_nwr"}, 64'(wr_addr.size()), 64'd2);
    if (wr_addr.size() == 2) begin
      chk({p, "_a0"}, 64'(wr_addr[0]), 64'h0);
      chk({p, "_d0"}, 64'(wr_data[0]), 64'h00500093);
      chk({p, "_a1"}, 64'(wr_addr[1]), 64'h1);
      chk({p, "_d1"}, 64'(wr_data[1]), 64'h00100113);
      chk({p, "_done_cyc"}, 64'(done_cyc - wr_cyc[1]), 64'd1);
    end
    chk({p, "_done"}, 64'(done), 64'd1);
    chk({p, "_core_reset"}, 64'(core_reset), 64'd0);
    chk({p, "_wl"}, 64'(words_loaded), 64'd2);
  endtask

  initial begin
    int bad;
    logic [31:0] w;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;

    // Reset state
    repeat (2) tick();
    @(negedge clk);
    chk("rst_s_ready", 64'(bus.s_ready), 64'd0);
    chk("rst_we", 64'(bus.imem_we), 64'd0);
    chk("rst_addr", 64'(bus.imem_addr), 64'd0);
    chk("rst_wdata", 64'(bus.imem_wdata), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_core_reset", 64'(core_reset), 64'd1);
    chk("rst_wl", 64'(words_loaded), 64'd0);
    tick();
    reset = 1'b0;
    tick();
    @(negedge clk);
    chk("post_rst_s_ready", 64'(bus.s_ready), 64'd1);
    chk("post_rst_core_reset", 64'(core_reset), 64'd1);
    tick();

    // Two-word load, continuous
    clear_log();
    load_two_word_tx();
    send_range(0, 9, 0);
    wait_end(50);
    chk_two_word("cont");
    if (wr_cyc.size() == 2) chk("cont_spacing", 64'(wr_cyc[1] - wr_cyc[0]), 64'd5);

    // Two-word load with 3-cycle gaps; extra bytes offered in DONE must not be taken
    do_reset();
    send_range(0, 9, 3);
    wait_end(100);
    chk_two_word("gap");
    if (wr_cyc.size() == 2 && xfer_cyc.size() == 10) begin
      chk("gap_w0_after_byte", 64'(wr_cyc[0] - xfer_cyc[5]), 64'd1);
      chk("gap_w1_after_byte", 64'(wr_cyc[1] - xfer_cyc[9]), 64'd1);
    end
    bus.s_valid = 1'b1;
    bus.s_data  = 8'hFF;
    repeat (3) tick();
    @(negedge clk);
    chk("done_s_ready", 64'(bus.s_ready), 64'd0);
    tick();
    bus.s_valid = 1'b0;
    chk("gap_nxfer", 64'(xfer_cyc.size()), 64'd10);

    // N = 0
    do_reset();
    tx = {8'h00, 8'h00};
    send_range(0, 1, 0);
    wait_end(20);
    chk("n0_done", 64'(done), 64'd1);
    chk("n0_nwr", 64'(wr_addr.size()), 64'd0);
    chk("n0_wl", 64'(words_loaded), 64'd0);

    // N = 257
    do_reset();
    tx = {8'h01, 8'h01};
    send_range(0, 1, 0);
    wait_end(20);
    repeat (3) tick();
    @(negedge clk);
    chk("n257_error", 64'(error), 64'd1);
    chk("n257_done", 64'(done), 64'd0);
    chk("n257_core_reset", 64'(core_reset), 64'd1);
    chk("n257_s_ready", 64'(bus.s_ready), 64'd0);
    chk("n257_nwr", 64'(wr_addr.size()), 64'd0);
    tick();

    // N = 256, full capacity
    do_reset();
    tx = {8'h00, 8'h01};
    for (int i = 0; i < 256; i++) begin
      w = {8'(i), 8'(~i), 8'h5A, 8'(i ^ 8'h3C)};
      tx.push_back(w[7:0]);
      tx.push_back(w[15:8]);
      tx.push_back(w[23:16]);
      tx.push_back(w[31:24]);
    end
    send_range(0, tx.size() - 1, 0);
    wait_end(50);
    chk("n256_nwr", 64'(wr_addr.size()), 64'd256);
    bad = 0;
    for (int i = 0; i < wr_addr.size() && i < 256; i++) begin
      w = {8'(i), 8'(~i), 8'h5A, 8'(i ^ 8'h3C)};
      if (wr_addr[i] !== 8'(i) || wr_data[i] !== w) bad++;
    end
    chk("n256_bad_words", 64'(bad), 64'd0);
    if (wr_addr.size() == 256) chk("n256_last_data", 64'(wr_data[255]), 64'hFF005AC3);
    chk("n256_done", 64'(done), 64'd1);
    chk("n256_wl", 64'(words_loaded), 64'd256);

    // Reset after 6 bytes of a two-word load
    do_reset();
    load_two_word_tx();
    send_range(0, 5, 0);
    reset = 1'b1;
    tick();
    @(negedge clk);
    chk("midrst_s_ready", 64'(bus.s_ready), 64'd0);
    chk("midrst_we", 64'(bus.imem_we), 64'd0);
    chk("midrst_addr", 64'(bus.imem_addr), 64'd0);
    chk("midrst_wdata", 64'(bus.imem_wdata), 64'd0);
    chk("midrst_core_reset", 64'(core_reset), 64'd1);
    chk("midrst_wl", 64'(words_loaded), 64'd0);
    tick();
    reset = 1'b0;
    tick();
    clear_log();
    tx = {8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_range(0, 5, 0);
    wait_end(30);
    chk("fresh_nwr", 64'(wr_addr.size()), 64'd1);
    if (wr_addr.size() == 1) begin
      chk("fresh_a0", 64'(wr_addr[0]), 64'h0);
      chk("fresh_d0", 64'(wr_data[0]), 64'hDEADBEEF);
    end
    chk("fresh_done", 64'(done), 64'd1);

    // Reload from DONE
    clear_log();
    reload = 1'b1;
    tick();
    reload = 1'b0;
    @(negedge clk);
    chk("reload_core_reset", 64'(core_reset), 64'd1);
    chk("reload_done", 64'(done), 64'd0);
    chk("reload_wl", 64'(words_loaded), 64'd0);
    tick();
    send_range(0, 5, 0);
    wait_end(30);
    chk("reload_nwr", 64'(wr_addr.size()), 64'd1);
    if (wr_addr.size() == 1) begin
      chk("reload_a0", 64'(wr_addr[0]), 64'h0);
      chk("reload_d0", 64'(wr_data[0]), 64'hDEADBEEF);
    end
    chk("reload_done2", 64'(done), 64'd1);
    chk("reload_wl2", 64'(words_loaded), 64'd1);

    // Reload pulsed in DATA is ignored
    do_reset();
    load_two_word_tx();
    send_range(0, 3, 0);
    reload = 1'b1;
    tick();
    reload = 1'b0;
    send_range(4, 9, 0);
    wait_end(50);
    chk_two_word("ign");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
